// File: rtl/i2s_rx.sv
// I2S receiver (codec is master): oversamples bclk/lrc/sdat in clk, deserializes MSB-first
// stereo words, emits one left/right pair per frame. Optional sticky overrun: I2S_RX_OVERRUN_EN.
module i2s_rx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                bclk,
    input  logic                lrc,
    input  logic                sdat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SAMPLE_W);
    localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrc_sync_q,  lrc_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic                   bclk_last_q, bclk_last_d;
    logic                   lrc_last_q,  lrc_last_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [SAMPLE_W-1:0]    shift_q,     shift_d;
    state_t                 state_q,     state_d;
    logic [SAMPLE_W-1:0]    left_hold_q, left_hold_d;
    logic [SAMPLE_W-1:0]    right_hold_q, right_hold_d;
    logic                   frame_done_q, frame_done_d;
    logic                   out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0]    out_left_q,  out_left_d;
    logic [SAMPLE_W-1:0]    out_right_q, out_right_d;
    logic                   overrun_q,   overrun_d;

    logic                   bclk_s;
    logic                   lrc_s;
    logic                   sdat_s;
    logic                   rise_s;
    logic                   trans_s;
    logic                   lrc_fall_s;
    logic                   lrc_rise_s;
    logic [SAMPLE_W-1:0]    shift_cap_s;
    logic                   load_left_s;
    logic                   load_right_s;
    logic                   load_out_s;
    logic                   pop_s;
    logic                   ovf_event_s;

    // Synchronizer chains and bclk edge history.
    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
        lrc_sync_d  = {lrc_sync_q[SYNC_STAGES-2:0],  lrc};
        sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], sdat};
        bclk_s      = bclk_sync_q[SYNC_STAGES-1];
        lrc_s       = lrc_sync_q[SYNC_STAGES-1];
        sdat_s      = sdat_sync_q[SYNC_STAGES-1];
        bclk_last_d = bclk_s;
    end

    // Rise / LRC transition decode.
    always_comb begin
        rise_s     = bclk_s & ~bclk_last_q;
        trans_s    = rise_s & (lrc_s != lrc_last_q);
        lrc_fall_s = trans_s & ~lrc_s;
        lrc_rise_s = trans_s & lrc_s;
    end

    // Shift register with the current bit inserted; bits past SAMPLE_W are dropped.
    always_comb begin
        if ((bit_cnt_q < CNT_MAX) && sdat_s) begin
            shift_cap_s = shift_q | (MSB_ONE >> bit_cnt_q);
        end else begin
            shift_cap_s = shift_q;
        end
    end

    // Protocol FSM: next state, hold-register loads and frame strobe.
    always_comb begin
        state_d      = state_q;
        load_left_s  = 1'b0;
        load_right_s = 1'b0;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (lrc_fall_s) begin
                        state_d = ST_LEFT;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LEFT: begin
                    if (lrc_rise_s) begin
                        state_d     = ST_RIGHT;
                        load_left_s = 1'b1;
                    end else begin
                        state_d = ST_LEFT;
                    end
                end
                ST_RIGHT: begin
                    if (lrc_fall_s) begin
                        state_d      = ST_LEFT;
                        load_right_s = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_RIGHT;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Deserializer: shift/bit_cnt restart after a transition (the transition bit closes the old slot).
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        lrc_last_d   = lrc_last_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        if (rise_s) begin
            lrc_last_d = lrc_s;
        end else begin
            lrc_last_d = lrc_last_q;
        end
        if (!enable) begin
            shift_d   = {SAMPLE_W{1'b0}};
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (trans_s) begin
            shift_d   = {SAMPLE_W{1'b0}};
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (rise_s) begin
            shift_d = shift_cap_s;
            if (bit_cnt_q < CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            shift_d   = shift_q;
            bit_cnt_d = bit_cnt_q;
        end
        if (load_left_s) begin
            left_hold_d = shift_cap_s;
        end else begin
            left_hold_d = left_hold_q;
        end
        if (load_right_s) begin
            right_hold_d = shift_cap_s;
        end else begin
            right_hold_d = right_hold_q;
        end
    end

    // Single-entry output register; a frame arriving while the held pair is unaccepted is dropped.
    always_comb begin
        load_out_s  = frame_done_q & (~out_valid_q | out_ready);
        pop_s       = out_valid_q & out_ready;
        ovf_event_s = frame_done_q & out_valid_q & ~out_ready;
        out_valid_d = out_valid_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        if (load_out_s) begin
            out_valid_d = 1'b1;
            out_left_d  = left_hold_q;
            out_right_d = right_hold_q;
        end else if (pop_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    // Sticky overrun: a coincident event wins over the clear.
    always_comb begin
        overrun_d = overrun_q;
        if (ovf_event_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end
`else
    logic unused_ovf_s;
    assign unused_ovf_s = overrun_clr ^ ovf_event_s;

    // Overrun reporting compiled out; the flag stays low.
    always_comb begin
        overrun_d = 1'b0;
    end
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q  <= {SYNC_STAGES{1'b0}};
            lrc_sync_q   <= {SYNC_STAGES{1'b0}};
            sdat_sync_q  <= {SYNC_STAGES{1'b0}};
            bclk_last_q  <= 1'b0;
            lrc_last_q   <= 1'b0;
            bit_cnt_q    <= {CNT_W{1'b0}};
            shift_q      <= {SAMPLE_W{1'b0}};
            state_q      <= ST_HUNT;
            left_hold_q  <= {SAMPLE_W{1'b0}};
            right_hold_q <= {SAMPLE_W{1'b0}};
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_left_q   <= {SAMPLE_W{1'b0}};
            out_right_q  <= {SAMPLE_W{1'b0}};
            overrun_q    <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrc_sync_q   <= lrc_sync_d;
            sdat_sync_q  <= sdat_sync_d;
            bclk_last_q  <= bclk_last_d;
            lrc_last_q   <= lrc_last_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            state_q      <= state_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bclk = clk/8, SAMPLE_W = 16, I2S framing with one-bit delay.
module tb_i2s_rx;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        bclk;
    logic        lrc;
    logic        sdat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        overrun;
    logic        overrun_clr;

    int   n_checks;
    int   n_errors;
    logic prev_lsb;
    bit   skip_first;

`ifdef I2S_RX_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    i2s_rx #(.SAMPLE_W(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bclk        (bclk),
        .lrc         (lrc),
        .sdat        (sdat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_left    (out_left),
        .out_right   (out_right),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bclk period: low 4 clk with lrc/sdat updated, then high.
    task automatic bit_period(input logic ch, input logic d);
        @(negedge clk);
        bclk = 1'b0;
        lrc  = ch;
        sdat = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Periods first..last-1 of an n-bit slot; period 0 carries the previous slot's LSB.
    task automatic bits(input logic ch, input logic [31:0] w, input int n, input int first, input int last);
        for (int i = first; i < last; i++) begin
            if (i == 0) begin
                bit_period(ch, prev_lsb);
            end else begin
                bit_period(ch, w[n-i]);
            end
        end
        if (last == n) prev_lsb = w[0];
        skip_first = 1'b0;
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
        bits(1'b0, l, n, skip_first ? 1 : 0, n);
        bits(1'b1, r, n, 0, n);
    endtask

    // First period of the next left slot; its rise closes the right slot.
    task automatic close_frame(input bit timed, input bit pop_on_load);
        @(negedge clk);
        bclk = 1'b0;
        lrc  = 1'b0;
        sdat = prev_lsb;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (timed) check_val("lat_early", 32'(out_valid), 32'd0);
        if (pop_on_load) out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (timed) check_val("lat_edge", 32'(out_valid), 32'd1);
        skip_first = 1'b1;
    endtask

    task automatic check_pair(input string tag, input logic [15:0] l, input logic [15:0] r);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_left"},  32'(out_left),  32'(l));
        check_val({tag, "_right"}, 32'(out_right), 32'(r));
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("pop_clr", 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        prev_lsb    = 1'b0;
        skip_first  = 1'b0;
        reset       = 1'b1;
        enable      = 1'b1;
        bclk        = 1'b0;
        lrc         = 1'b0;
        sdat        = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_valid",   32'(out_valid), 32'd0);
        check_val("rst_left",    32'(out_left),  32'd0);
        check_val("rst_right",   32'(out_right), 32'd0);
        check_val("rst_overrun", 32'(overrun),   32'd0);
        reset = 1'b0;

        // Priming frame, then basic frame with latency check.
        frame(32'hDEAD_BEEF, 32'h1357_9BDF, 32);
        frame(32'h8001_00FF, 32'h7FFE_FF00, 32);
        close_frame(1'b1, 1'b0);
        check_pair("basic", 16'h8001, 16'h7FFE);
        pop();

        // Long and short slots.
        frame(32'h00AB_CDEF, 32'h0012_3456, 24);
        close_frame(1'b0, 1'b0);
        check_pair("slot24", 16'hABCD, 16'h1234);
        pop();
        frame(32'h0000_0FFF, 32'h0000_0801, 12);
        close_frame(1'b0, 1'b0);
        check_pair("slot12", 16'hFFF0, 16'h8010);
        pop();

        // Back-pressure for three frames.
        frame(32'h1111_0000, 32'h2222_0000, 32);
        close_frame(1'b0, 1'b0);
        check_pair("bp_first", 16'h1111, 16'h2222);
        frame(32'h3333_0000, 32'h4444_0000, 32);
        close_frame(1'b0, 1'b0);
        frame(32'h5555_0000, 32'h6666_0000, 32);
        close_frame(1'b0, 1'b0);
        check_pair("bp_held", 16'h1111, 16'h2222);
        check_val("bp_overrun", 32'(overrun), 32'(EXP_OVR));
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'd0);
        pop();

        // Simultaneous pop and load.
        frame(32'hA5A5_0000, 32'h5A5A_0000, 32);
        close_frame(1'b0, 1'b0);
        check_pair("sim_d", 16'hA5A5, 16'h5A5A);
        frame(32'hC3C3_0000, 32'h3C3C_0000, 32);
        close_frame(1'b0, 1'b1);
        check_pair("sim_e", 16'hC3C3, 16'h3C3C);
        check_val("sim_overrun", 32'(overrun), 32'd0);
        pop();

        // Reset released during a right slot.
        bits(1'b0, 32'h0F0F_0000, 32, 1, 32);
        bits(1'b1, 32'hF0F0_0000, 32, 0, 10);
        pulse_reset();
        check_val("rstr_valid", 32'(out_valid), 32'd0);
        bits(1'b1, 32'hF0F0_0000, 32, 10, 32);
        frame(32'h1234_0000, 32'hFEDC_0000, 32);
        check_val("rstr_noemit", 32'(out_valid), 32'd0);
        close_frame(1'b0, 1'b0);
        check_pair("rstr", 16'h1234, 16'hFEDC);
        pop();

        // Reset pulsed mid-left-slot: that frame is lost.
        bits(1'b0, 32'h7777_0000, 32, 1, 12);
        pulse_reset();
        bits(1'b0, 32'h7777_0000, 32, 12, 32);
        bits(1'b1, 32'h8888_0000, 32, 0, 32);
        frame(32'h0246_0000, 32'h8ACE_0000, 32);
        check_val("rstl_noemit", 32'(out_valid), 32'd0);
        close_frame(1'b0, 1'b0);
        check_pair("rstl", 16'h0246, 16'h8ACE);

        // Enable dropped mid-frame with a pair held.
        bits(1'b0, 32'h9999_0000, 32, 1, 32);
        bits(1'b1, 32'hAAAA_0000, 32, 0, 8);
        enable = 1'b0;
        bits(1'b1, 32'hAAAA_0000, 32, 8, 20);
        check_pair("en_held", 16'h0246, 16'h8ACE);
        pop();
        enable = 1'b1;
        bits(1'b1, 32'hAAAA_0000, 32, 20, 32);
        frame(32'h4321_0000, 32'hBCDE_0000, 32);
        check_val("en_noemit", 32'(out_valid), 32'd0);
        close_frame(1'b0, 1'b0);
        check_pair("en_resume", 16'h4321, 16'hBCDE);
        pop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
